adder_result_accumulator: RTL



---
 rtl/adder_result_accumulator.sv | 104 ++++++++++
 1 files changed

// File: rtl/adder_result_accumulator.sv
// adder_result_accumulator
// Collects COUNT results from the 4-bit adder ({carry, sum}) into a
// saturating running total, then offers the frame total and an overflow
// flag downstream on a valid/ready handshake. All outputs are registered;
// in_ready and out_valid are pure decodes of the state register.
module adder_result_accumulator #(
  parameter int SUM_W = 4,
  parameter int ACC_W = 8,
  parameter int COUNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] in_sum,
  input  logic             in_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic             out_ovf
);

  localparam int CNT_W = $clog2(COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(COUNT);

  typedef enum logic {
    ACCUM,
    DONE
  } state_e;

  state_e           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic             ovf_d;
  logic [ACC_W-1:0] total_q;
  logic             totalOvf_q;
  logic [SUM_W:0]   sample;
  logic [ACC_W:0]   sumWide;
  logic             lastSample;

  // Saturating add of the incoming sample, using one extra bit so an
  // overflow is detected instead of wrapping the accumulator.
  always_comb begin
    sample     = {in_cout, in_sum};
    sumWide    = {1'b0, acc_q} + (ACC_W + 1)'(sample);
    acc_d      = sumWide[ACC_W] ? '1 : sumWide[ACC_W-1:0];
    ovf_d      = ovf_q | sumWide[ACC_W];
    lastSample = (cnt_q == CNT_LAST);
  end

  // Frame FSM: accumulate while in ACCUM, latch the total into the output
  // registers on the last accept, hold it in DONE until downstream takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ACCUM;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      total_q    <= '0;
      totalOvf_q <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_valid) begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
            if (lastSample) begin
              state_q    <= DONE;
              cnt_q      <= CNT_FULL;
              total_q    <= acc_d;
              totalOvf_q <= ovf_d;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= ACCUM;
        end
      endcase
    end
  end

  // Handshake flags decode the state alone, so neither ready path is
  // combinationally coupled to the neighbouring stages.
  always_comb begin
    in_ready  = (state_q == ACCUM);
    out_valid = (state_q == DONE);
    out_total = total_q;
    out_ovf   = totalOvf_q;
  end

endmodule
